// File: rtl/hangman_pkg.sv
// Shared constants and scan-code map for the hangman letter path.
// Macro HANGMAN_DISP_FILTER_EN drops letters with no 7-segment glyph.
package hangman_pkg;

  localparam logic [5:0] LTR_DASH = 6'h00;
  localparam logic [5:0] LTR_A = 6'h0A;
  localparam logic [5:0] LTR_B = 6'h0B;
  localparam logic [5:0] LTR_C = 6'h0C;
  localparam logic [5:0] LTR_D = 6'h0D;
  localparam logic [5:0] LTR_E = 6'h0E;
  localparam logic [5:0] LTR_F = 6'h0F;
  localparam logic [5:0] LTR_G = 6'h10;
  localparam logic [5:0] LTR_H = 6'h11;
  localparam logic [5:0] LTR_I = 6'h12;
  localparam logic [5:0] LTR_J = 6'h13;
  localparam logic [5:0] LTR_K = 6'h14;
  localparam logic [5:0] LTR_L = 6'h15;
  localparam logic [5:0] LTR_M = 6'h16;
  localparam logic [5:0] LTR_N = 6'h17;
  localparam logic [5:0] LTR_O = 6'h18;
  localparam logic [5:0] LTR_P = 6'h19;
  localparam logic [5:0] LTR_Q = 6'h1A;
  localparam logic [5:0] LTR_R = 6'h1B;
  localparam logic [5:0] LTR_S = 6'h1C;
  localparam logic [5:0] LTR_T = 6'h1D;
  localparam logic [5:0] LTR_U = 6'h1E;
  localparam logic [5:0] LTR_V = 6'h1F;
  localparam logic [5:0] LTR_W = 6'h20;
  localparam logic [5:0] LTR_X = 6'h21;
  localparam logic [5:0] LTR_Y = 6'h22;
  localparam logic [5:0] LTR_Z = 6'h23;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef struct packed {
    logic       hit;
    logic [5:0] code;
  } scan_hit_t;

  function automatic scan_hit_t scan_map(input logic [7:0] sc);
    scan_hit_t r;
    r.hit  = 1'b1;
    r.code = LTR_DASH;
    case (sc)
      8'h1C: r.code = LTR_A;
      8'h32: r.code = LTR_B;
      8'h21: r.code = LTR_C;
      8'h23: r.code = LTR_D;
      8'h24: r.code = LTR_E;
      8'h2B: r.code = LTR_F;
      8'h34: r.code = LTR_G;
      8'h33: r.code = LTR_H;
      8'h43: r.code = LTR_I;
      8'h3B: r.code = LTR_J;
      8'h42: r.code = LTR_K;
      8'h4B: r.code = LTR_L;
      8'h3A: r.code = LTR_M;
      8'h31: r.code = LTR_N;
      8'h44: r.code = LTR_O;
      8'h4D: r.code = LTR_P;
      8'h15: r.code = LTR_Q;
      8'h2D: r.code = LTR_R;
      8'h1B: r.code = LTR_S;
      8'h2C: r.code = LTR_T;
      8'h3C: r.code = LTR_U;
      8'h2A: r.code = LTR_V;
      8'h1D: r.code = LTR_W;
      8'h22: r.code = LTR_X;
      8'h35: r.code = LTR_Y;
      8'h1A: r.code = LTR_Z;
      default: r.hit = 1'b0;
    endcase
`ifdef HANGMAN_DISP_FILTER_EN
    if (r.code == LTR_K || r.code == LTR_M ||
        r.code == LTR_V || r.code == LTR_W ||
        r.code == LTR_X || r.code == LTR_Z)
      r.hit = 1'b0;
`endif
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, 11-bit frame FSM, timeout.
// Emits one byte_strobe per good frame, frame_err pulse otherwise.
module ps2_frame_rx
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;
  logic [1:0]             state;
  logic [3:0]             bit_cnt;
  logic [9:0]             shreg;
  logic [TW-1:0]          tmo_cnt;
  logic                   tmo_hit;
  logic                   good;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_q & ~clk_s;
  assign tmo_hit = (tmo_cnt == TMO_MAX);
  assign good    = shreg[9] & (^shreg[8:0]);

  assign data_byte   = shreg[7:0];
  assign byte_strobe = (state == S_CHECK) & good;

  // Bring the raw pins into the clock domain; idle level is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_q    <= clk_s;
    end
  end

  // Cycles since the last PS/2 falling edge, saturating.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      tmo_cnt <= '0;
    else if (fall)
      tmo_cnt <= '0;
    else if (!tmo_hit)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Frame FSM: start bit, 8 data, parity, stop, then one check cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall) begin
            if (!dat_s) begin
              state   <= S_RECV;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (fall) begin
            shreg <= {dat_s, shreg[9:1]};
            if (bit_cnt == 4'd9)
              state <= S_CHECK;
            else
              bit_cnt <= bit_cnt + 4'd1;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            shreg     <= '0;
            state     <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (!good)
            frame_err <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hangman_letter_encoder.sv
// PS/2 set-2 keyboard to 6-bit hangman letter code, held handshake.
// Define HANGMAN_DISP_FILTER_EN to suppress letters with no glyph.
module hangman_letter_encoder
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [5:0] letter_code,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic       frame_err,
  output logic       overrun
);

  logic [7:0] rx_byte;
  logic       rx_stb;
  logic       ext;
  logic       brk;
  logic       is_pfx;
  logic       emit;
  logic       xfer;
  scan_hit_t  lk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .data_byte  (rx_byte),
    .byte_strobe(rx_stb),
    .frame_err  (frame_err)
  );

  assign lk     = scan_map(rx_byte);
  assign is_pfx = (rx_byte == SC_EXT) | (rx_byte == SC_BRK);
  assign emit   = rx_stb & ~is_pfx & ~ext & ~brk & lk.hit;
  assign xfer   = letter_valid & letter_ready;

  // Prefix flags: a prefixed byte is swallowed and clears both flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_stb) begin
      if (rx_byte == SC_EXT)
        ext <= 1'b1;
      else if (rx_byte == SC_BRK)
        brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // Output holding register; a letter arriving while one is stuck is dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      letter_code  <= LTR_DASH;
      letter_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (emit) begin
      if (!letter_valid || xfer) begin
        letter_code  <= lk.code;
        letter_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (xfer) begin
      letter_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hangman_letter_encoder.sv
// Directed bench for hangman_letter_encoder.
// Short timeout parameter keeps the timeout case quick.
module tb_hangman_letter_encoder;

  localparam int TMO = 100;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [5:0] letter_code;
  logic       letter_valid;
  logic       letter_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int n_pass = 0;
  int n_chk  = 0;
  int n_err  = 0;
  logic [5:0] acc_q[$];

  hangman_letter_encoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .letter_code (letter_code),
    .letter_valid(letter_valid),
    .letter_ready(letter_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn && letter_valid && letter_ready)
      acc_q.push_back(letter_code);
    if (resetn && frame_err)
      n_err++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(5);
    ps2_clk = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip);
    logic p;
    p = ~(^d) ^ flip;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic flip = 1'b0);
    logic [10:0] f;
    f = mk(d, flip);
    for (int i = 0; i < 11; i++)
      send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [10:0] f;
    int e0;

    tick(3);
    chk("rst_code", letter_code, 6'h00);
    chk("rst_valid", letter_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    resetn = 1'b1;
    tick(3);

    // Exact latency on 1C
    f = mk(8'h1C, 1'b0);
    for (int i = 0; i < 10; i++)
      send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    chk("lat_lo", letter_valid, 0);
    tick(1);
    chk("lat_hi", letter_valid, 1);
    chk("lat_code", letter_code, 6'h0A);
    tick(1);
    chk("lat_clr", letter_valid, 0);
    chk("lat_hold", letter_code, 6'h0A);
    tick(4);
    ps2_clk = 1'b1;
    tick(8);
    chk("t1_n", acc_q.size(), 1);

    // Break and extended prefixes swallow the following byte
    acc_q.delete();
    send_frame(8'hF0);
    send_frame(8'h1C);
    send_frame(8'hE0);
    send_frame(8'h32);
    chk("brk_none", acc_q.size(), 0);
    send_frame(8'h1C);
    chk("brk_n", acc_q.size(), 1);
    if (acc_q.size() > 0)
      chk("brk_code", acc_q[0], 6'h0A);

    // Non-letter make code
    acc_q.delete();
    send_frame(8'h16);
    chk("nonltr", acc_q.size(), 0);

    // Bad parity
    e0 = n_err;
    send_frame(8'h1C, 1'b1);
    chk("par_err", n_err - e0, 1);
    chk("par_none", acc_q.size(), 0);
    send_frame(8'h35);
    chk("par_n", acc_q.size(), 1);
    if (acc_q.size() > 0)
      chk("par_next", acc_q[0], 6'h22);

    // Timeout mid-frame
    acc_q.delete();
    e0 = n_err;
    f = mk(8'h4D, 1'b0);
    for (int i = 0; i < 5; i++)
      send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(TMO + 50);
    chk("tmo_err", n_err - e0, 1);
    chk("tmo_none", acc_q.size(), 0);
    send_frame(8'h4D);
    chk("tmo_n", acc_q.size(), 1);
    if (acc_q.size() > 0)
      chk("tmo_next", acc_q[0], 6'h19);

    // Overrun while consumer stalls
    acc_q.delete();
    letter_ready = 1'b0;
    send_frame(8'h1C);
    send_frame(8'h32);
    chk("ovr_valid", letter_valid, 1);
    chk("ovr_code", letter_code, 6'h0A);
    chk("ovr_flag", overrun, 1);
    letter_ready = 1'b1;
    tick(2);
    send_frame(8'h21);
    chk("ovr_n", acc_q.size(), 2);
    if (acc_q.size() > 1) begin
      chk("ovr_old", acc_q[0], 6'h0A);
      chk("ovr_new", acc_q[1], 6'h0C);
    end
    chk("ovr_sticky", overrun, 1);

    // K, filtered only when the glyph filter is built in
    acc_q.delete();
    send_frame(8'h42);
`ifdef HANGMAN_DISP_FILTER_EN
    chk("k_n", acc_q.size(), 0);
`else
    chk("k_n", acc_q.size(), 1);
    if (acc_q.size() > 0)
      chk("k_code", acc_q[0], 6'h14);
`endif

    // Reset mid-frame
    acc_q.delete();
    f = mk(8'h24, 1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(f[i]);
    ps2_dat = 1'b1;
    resetn = 1'b0;
    #1;
    chk("mrst_code", letter_code, 6'h00);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_valid", letter_valid, 0);
    tick(2);
    resetn = 1'b1;
    tick(3);
    send_frame(8'h24);
    chk("mrst_n", acc_q.size(), 1);
    if (acc_q.size() > 0)
      chk("mrst_code2", acc_q[0], 6'h0E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
